sram_controller: RTL

- Synchronous initiator for the asynchronous `SRAM` block: 256K x 8, active-low `bCE`/`bWE`, level-sensitive write.
- Converts a single-cycle valid/ready request interface into correctly sequenced SRAM control.
- Sequencing keeps `Address`/`InData` stable around every `bWE` low pulse.
- Sits between the lab datapath or FSM and the SRAM model. Returns read data and write acknowledges on a one-cycle response strobe.

---
 rtl/sram_controller.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// sram_controller: synchronous initiator for the 256K x 8 asynchronous SRAM.
// It turns a single-cycle valid/ready request into a SETUP / strobe / HOLD
// sequence. Address and write data stay stable on both sides of every bWE
// low pulse, so level-sensitive writes are safe.
// Optional feature: define SRAM_CTRL_VERIFY_EN to add a read-back VERIFY
// phase after each write, plus a WriteError output pulse.
module sram_controller #(
  parameter int AddressSize = 18,
  parameter int WordSize    = 8,
  parameter int WaitCycles  = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic                   ReqWrite,
  input  logic [AddressSize-1:0] ReqAddress,
  input  logic [WordSize-1:0]    ReqData,
  output logic                   RespValid,
  output logic [WordSize-1:0]    RespData,
  output logic                   Busy,
  output logic [AddressSize-1:0] Address,
  output logic [WordSize-1:0]    InData,
  input  logic [WordSize-1:0]    OutData,
  output logic                   bCE,
`ifdef SRAM_CTRL_VERIFY_EN
  output logic                   bWE,
  output logic                   WriteError
`else
  output logic                   bWE
`endif
);

  // WaitCycles is limited to 1..15, so a 4-bit down-counter is always enough.
  localparam logic [3:0] WAIT_LOAD = 4'(WaitCycles - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_WRITE  = 3'd2,
    S_HOLD   = 3'd3,
`ifdef SRAM_CTRL_VERIFY_EN
    S_READ   = 3'd4,
    S_VERIFY = 3'd5
`else
    S_READ   = 3'd4
`endif
  } state_t;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic                   write_q;
  logic                   bce_q;
  logic                   bwe_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   rvalid_q;
  logic [AddressSize-1:0] addr_q;
  logic [WordSize-1:0]    indata_q;
  logic [WordSize-1:0]    rdata_q;
`ifdef SRAM_CTRL_VERIFY_EN
  logic                   werr_q;
`endif

  // Single-process FSM. Every SRAM-facing and response output is a register,
  // so it changes together with the state it belongs to.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      bce_q    <= 1'b1;
      bwe_q    <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      addr_q   <= '0;
      indata_q <= '0;
      rdata_q  <= '0;
`ifdef SRAM_CTRL_VERIFY_EN
      werr_q   <= 1'b0;
`endif
    end else begin
      // The response strobes are one-cycle pulses by default.
      rvalid_q <= 1'b0;
`ifdef SRAM_CTRL_VERIFY_EN
      werr_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (ReqValid && ready_q) begin
            // The request is captured only here. In every other state the
            // Address and InData registers hold their values.
            addr_q  <= ReqAddress;
            write_q <= ReqWrite;
            if (ReqWrite) begin
              indata_q <= ReqData;
            end
            bce_q   <= 1'b0;
            bwe_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end

        S_SETUP: begin
          // Chip is enabled with the address settled one cycle before any
          // write strobe or read sampling window begins.
          cnt_q <= WAIT_LOAD;
          if (write_q) begin
            bwe_q   <= 1'b0;
            state_q <= S_WRITE;
          end else begin
            state_q <= S_READ;
          end
        end

        S_WRITE: begin
          if (cnt_q == 4'd0) begin
            bwe_q   <= 1'b1;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_HOLD: begin
          // bWE is already high here and Address/InData are unchanged, so
          // the data is held past the rising edge of the strobe.
`ifdef SRAM_CTRL_VERIFY_EN
          cnt_q   <= WAIT_LOAD;
          state_q <= S_VERIFY;
`else
          bce_q    <= 1'b1;
          rvalid_q <= 1'b1;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
`endif
        end

        S_READ: begin
          if (cnt_q == 4'd0) begin
            rdata_q  <= OutData;
            bce_q    <= 1'b1;
            rvalid_q <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

`ifdef SRAM_CTRL_VERIFY_EN
        S_VERIFY: begin
          // Read back the location just written and compare it with the
          // data that is still held in InData. RespData is left untouched.
          if (cnt_q == 4'd0) begin
            werr_q   <= (OutData != indata_q);
            bce_q    <= 1'b1;
            rvalid_q <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`endif

        default: begin
          bce_q   <= 1'b1;
          bwe_q   <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ReqReady   = ready_q;
  assign RespValid  = rvalid_q;
  assign RespData   = rdata_q;
  assign Busy       = busy_q;
  assign Address    = addr_q;
  assign InData     = indata_q;
  assign bCE        = bce_q;
  assign bWE        = bwe_q;
`ifdef SRAM_CTRL_VERIFY_EN
  assign WriteError = werr_q;
`endif

endmodule
